// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
// Operand magnitudes are formed one bit wider than the operand so -2^(W-1) stays exact.
package seq_mult_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} seq_mult_state_t;

  // Widest operand the magnitude helper handles; callers truncate to WIDTH+1.
  localparam int MAG_MAX_W = 64;

  function automatic logic [MAG_MAX_W:0] mag(input logic [MAG_MAX_W-1:0] value,
                                             input int                   width,
                                             input logic                 signed_flag);
    logic [MAG_MAX_W:0] ext;
    logic [MAG_MAX_W:0] full;
    logic               msb;
    ext  = {1'b0, value};
    full = (MAG_MAX_W+1)'(1) << width;
    msb  = |(value & (MAG_MAX_W'(1) << (width - 1)));
    if (signed_flag && msb) return full - ext;
    return ext;
  endfunction

endpackage

// File: rtl/seq_mult_shift_add_if.sv
// Operand/result handshake bundle between the operand source, the multiplier
// and the result consumer.
interface seq_mult_shift_add_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Control FSM for the iterative multiplier: IDLE/BUSY/DONE sequencing,
// per-bit step counter and handshake outputs.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic in_valid,
  input  logic out_ready,
  input  logic rest_zero,
  output logic in_ready,
  output logic out_valid,
  output logic busy,
  output logic accept,
  output logic finish
);

  localparam int                STEP_W    = $clog2(WIDTH);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

  seq_mult_state_t   state_q;
  seq_mult_state_t   state_n;
  logic [STEP_W-1:0] step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_n;
      if (accept) begin
        step_q <= '0;
      end else if (state_q == BUSY) begin
        step_q <= step_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        // rest_zero looks at the multiplier after this edge's shift.
        if ((step_q == LAST_STEP) || (EARLY_EXIT && rest_zero)) begin
          finish  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/seq_mult_shift_add.sv
// Iterative shift-and-add multiplier: one multiplier bit per clock on operand
// magnitudes, with the sign applied once when the product is loaded.
module seq_mult_shift_add
  import seq_mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  seq_mult_shift_add_if.slave bus
);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH:0]     mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH:0]     a_mag;
  logic [WIDTH:0]     b_mag;
  logic               res_neg;
  logic [2*WIDTH-1:0] acc_sum;
  logic               rest_zero;
  logic               accept;
  logic               finish;
  logic               busy;

  function automatic logic signed [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] m,
                                                            input logic               neg);
    return neg ? -$signed(m) : $signed(m);
  endfunction

  seq_mult_ctrl #(
    .WIDTH      (WIDTH),
    .EARLY_EXIT (EARLY_EXIT)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (bus.in_valid),
    .out_ready (bus.out_ready),
    .rest_zero (rest_zero),
    .in_ready  (bus.in_ready),
    .out_valid (bus.out_valid),
    .busy      (busy),
    .accept    (accept),
    .finish    (finish)
  );

  always_comb begin
    a_mag     = (WIDTH+1)'(mag(MAG_MAX_W'(bus.a), WIDTH, bus.is_signed));
    b_mag     = (WIDTH+1)'(mag(MAG_MAX_W'(bus.b), WIDTH, bus.is_signed));
    res_neg   = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    rest_zero = (mplier_q[WIDTH:1] == '0);
  end

  // Multiplicand shifts left alongside the multiplier, so "shifted by step" is implicit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else if (clear) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else if (accept) begin
      mcand_q  <= {{(WIDTH-1){1'b0}}, a_mag};
      mplier_q <= b_mag;
      acc_q    <= '0;
      neg_q    <= res_neg;
    end else if (busy) begin
      acc_q    <= acc_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (finish) product_q <= apply_sign(acc_sum, neg_q);
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = busy;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Bench driving a default and an early-exit multiplier side by side with
// directed and random operands against an arithmetic reference.
module tb_seq_mult_shift_add;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  int   n_vec = 0;
  int   n_err = 0;

  seq_mult_shift_add_if #(.WIDTH(W)) bus0 ();
  seq_mult_shift_add_if #(.WIDTH(W)) bus1 ();

  seq_mult_shift_add #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus0)
  );

  seq_mult_shift_add #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input logic s);
    int av;
    int bv;
    av = s ? int'($signed(a)) : int'(a);
    bv = s ? int'($signed(b)) : int'(b);
    return 16'(av * bv);
  endfunction

  // Early-exit latency: index of the highest set magnitude bit plus one, at least 1.
  function automatic int ref_lat_early(input logic [7:0] b, input logic s);
    int mb;
    int k;
    mb = (s && b[7]) ? 256 - int'(b) : int'(b);
    k  = 1;
    while ((mb >> k) != 0) k++;
    return k;
  endfunction

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic s);
    bus0.in_valid = v; bus0.a = a; bus0.b = b; bus0.is_signed = s;
    bus1.in_valid = v; bus1.a = a; bus1.b = b; bus1.is_signed = s;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
    logic [15:0] exp;
    int          lat0;
    int          lat1;
    bit          got0;
    bit          got1;
    bit          rdy_ok;
    exp = ref_prod(a, b, s);
    got0 = 1'b0; got1 = 1'b0; lat0 = -1; lat1 = -1; rdy_ok = 1'b1;
    @(negedge clk);
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    check(32'(bus0.in_ready & bus1.in_ready), 32'd1, {tag, "_in_ready"});
    check(32'(bus0.out_valid), 32'd0, {tag, "_gap_no_valid"});
    drive(1'b1, a, b, s);
    @(posedge clk);
    #1;
    drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    for (int c = 1; c <= 3*W && !(got0 && got1); c++) begin
      @(negedge clk);
      if (!got0) begin
        if (bus0.in_ready !== 1'b0) rdy_ok = 1'b0;
        if (bus0.out_valid === 1'b1) begin
          got0 = 1'b1; lat0 = c - 1;
          check(32'(bus0.product), 32'(exp), {tag, "_prod"});
        end
      end
      if (!got1) begin
        if (bus1.in_ready !== 1'b0) rdy_ok = 1'b0;
        if (bus1.out_valid === 1'b1) begin
          got1 = 1'b1; lat1 = c - 1;
          check(32'(bus1.product), 32'(exp), {tag, "_prod_early"});
        end
      end
    end
    check(32'(lat0), 32'(W), {tag, "_lat"});
    check(32'(lat1), 32'(ref_lat_early(b, s)), {tag, "_lat_early"});
    check(32'(rdy_ok), 32'd1, {tag, "_no_accept_busy"});
  endtask

  initial begin
    logic [15:0] hold0;
    logic [15:0] hold1;
    bit          ok;
    bit          seen;

    rst_n = 1'b0;
    clear = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    bus0.out_ready = 1'b0;
    bus1.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check(32'(bus0.in_ready), 32'd1, "rst_in_ready");
    check(32'(bus0.out_valid | bus1.out_valid), 32'd0, "rst_out_valid");
    check(32'(bus0.busy | bus1.busy), 32'd0, "rst_busy");
    check(32'(bus0.product | bus1.product), 32'd0, "rst_product");
    rst_n = 1'b1;

    do_op(8'd13,  8'd11,  1'b0, "u13x11");
    do_op(8'hFD,  8'h05,  1'b1, "s_m3x5");
    do_op(8'h80,  8'h80,  1'b1, "s_min_sq");
    do_op(8'hFF,  8'hFF,  1'b0, "u_max_sq");
    do_op(8'd200, 8'd0,   1'b0, "u_b_zero");
    do_op(8'd255, 8'd3,   1'b0, "u255x3");
    do_op(8'h7F,  8'h80,  1'b1, "s_max_min");
    repeat (16) do_op(8'($urandom), 8'(8'($urandom) >> $urandom_range(0, 7)), 1'($urandom), "rand");

    // Backpressure: result held while the consumer stalls, new operands ignored.
    @(negedge clk);
    bus0.out_ready = 1'b0;
    bus1.out_ready = 1'b0;
    drive(1'b1, 8'd7, 8'd9, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 3*W && !seen; c++) begin
      @(negedge clk);
      if (bus0.out_valid === 1'b1) seen = 1'b1;
    end
    check(32'(seen), 32'd1, "bp_valid_seen");
    hold0 = bus0.product;
    hold1 = bus1.product;
    check(32'(hold0), 32'h3F, "bp_prod");
    check(32'(hold1), 32'h3F, "bp_prod_early");
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      if (bus0.out_valid !== 1'b1 || bus0.in_ready !== 1'b0 || bus0.product !== hold0) ok = 1'b0;
      if (bus1.out_valid !== 1'b1 || bus1.in_ready !== 1'b0 || bus1.product !== hold1) ok = 1'b0;
    end
    check(32'(ok), 32'd1, "bp_hold_stable");
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    check(32'(bus0.in_ready & bus1.in_ready), 32'd1, "bp_release_ready");
    check(32'(bus0.out_valid | bus1.out_valid), 32'd0, "bp_release_valid");
    check(32'(bus0.product), 32'h3F, "bp_product_kept");
    do_op(8'd21, 8'd12, 1'b0, "bp_next");

    // Asynchronous reset in the third BUSY cycle.
    do_op(8'd3, 8'd5, 1'b0, "pre_reset");
    @(negedge clk);
    drive(1'b1, 8'd100, 8'hC5, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check(32'(bus0.out_valid | bus1.out_valid), 32'd0, "arst_out_valid");
    check(32'(bus0.busy | bus1.busy), 32'd0, "arst_busy");
    check(32'(bus0.product), 32'd0, "arst_product");
    check(32'(bus1.product), 32'd0, "arst_product_early");
    check(32'(bus0.in_ready), 32'd1, "arst_in_ready");
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'd6, 8'd7, 1'b0, "post_reset");

    // Synchronous clear during BUSY discards the operation.
    @(negedge clk);
    drive(1'b1, 8'hAB, 8'hCD, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check(32'(bus0.busy | bus1.busy), 32'd0, "clr_busy");
    check(32'(bus0.in_ready & bus1.in_ready), 32'd1, "clr_in_ready");
    check(32'(bus0.product | bus1.product), 32'd0, "clr_product");
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) seen = 1'b1;
    end
    check(32'(seen), 32'd0, "clr_no_result");

    do_op(8'd2, 8'd3, 1'b0, "b2b_first");
    do_op(8'd4, 8'd5, 1'b0, "b2b_second");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_mult_shift_add.md
Name: seq_mult_shift_add

Overview:
Parametrised iterative shift-and-add multiplier. It replaces the repeated-addition datapath: one multiplier bit per clock instead of one addition per unit of the operand. It supports a per-operation signed/unsigned mode, optional early termination, and valid/ready handshakes on input and output. It sits between an operand source and a result consumer in the arithmetic datapath.

Parameters:
WIDTH, 8, operand width in bits (>=2); the product is 2*WIDTH bits.
EARLY_EXIT, 0, 1 = finish as soon as the remaining multiplier bits are all zero.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort; returns the block to IDLE
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier (iterated bit by bit)
is_signed  input  1  1 = a and b are two's complement
out_valid  output  1  product available
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  result
busy  output  1  state is BUSY

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset (rst_n=0, effective immediately): state=IDLE, product=0, out_valid=0, in_ready=1, busy=0, internal regs cleared.
- clear=1 at a rising edge: same values as reset, applied synchronously. Priority is rst_n > clear > all other inputs.
- State IDLE: in_ready=1.
  - Accept occurs when in_valid && in_ready at edge E0.
  - At E0 the block latches |a|, |b|, the result sign (a_msb ^ b_msb when is_signed, else 0), sets acc=0 and step=0, and moves to BUSY.
- State BUSY: in_ready=0, busy=1. Each edge processes one multiplier bit:
  - if the current LSB of the multiplier = 1, add the multiplicand shifted by step into acc (2*WIDTH bits, no overflow possible);
  - shift the multiplier right by 1;
  - step++.
- Leaving BUSY:
  - Default: at edge E_WIDTH, load product with acc (negated if sign=1), go to DONE.
  - EARLY_EXIT=1: at the first edge E_k (k>=1) after which the remaining multiplier is zero, load the corrected product and go to DONE.
  - A zero multiplier therefore gives latency 1.
- State DONE: out_valid=1.
  - product is held stable while out_ready=0; in_valid is ignored.
  - On out_valid && out_ready, go to IDLE. out_valid drops and in_ready rises the next cycle, so there is at least 1 idle cycle between results.
- Latency from accept edge to out_valid high: WIDTH cycles (EARLY_EXIT=0), or k cycles with 1<=k<=WIDTH (EARLY_EXIT=1).
- product keeps its last value after the handshake until the next result load, reset, or clear.
- Signed handling:
  - magnitudes are formed in WIDTH+1 bits so that -2^(WIDTH-1) is exact;
  - the final product fits in 2*WIDTH bits, e.g. -128*-128 = 16'h4000.
- is_signed, a and b are sampled only at the accept edge; changes during BUSY have no effect.
- clear during BUSY or DONE discards the operation; no out_valid is produced for it.

Decomposition:
- Package seq_mult_pkg:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} seq_mult_state_t;
  - function mag(value, signed_flag) returning the (WIDTH+1)-bit magnitude.
- Natural sub-module: seq_mult_ctrl, holding the FSM, step counter and handshake outputs. The top level holds the accumulator, shift registers and sign correction.

Test Plan:
- WIDTH=8, EARLY_EXIT=0, unsigned a=13, b=11 -> out_valid exactly 8 cycles after accept, product=16'h008F, in_ready=0 throughout.
- Signed a=8'hFD (-3), b=8'h05 -> product=16'hFFF1. Signed a=b=8'h80 -> product=16'h4000. Unsigned a=b=8'hFF -> product=16'hFE01.
- EARLY_EXIT=1: a=200, b=0 -> out_valid 1 cycle after accept, product=0. a=255, b=3 -> latency 2, product=16'h02FD.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and new operands -> product and out_valid stable, in_ready=0, nothing accepted. Release out_ready -> in_ready=1 next cycle, new operands accepted.
- rst_n asserted asynchronously at the 3rd BUSY cycle -> outputs go immediately to out_valid=0, product=0, busy=0. After release, in_ready=1 and a fresh 6*7 yields 16'h002A.
- clear=1 for one edge during BUSY -> IDLE next cycle, no out_valid for the aborted operation. Back-to-back 2*3 then 4*5 -> 16'h0006 then 16'h0014, with a 1-cycle gap between them.
